// File: rtl/mux_2to1.sv
// Word-wide 2:1 operand-select multiplexer with a combinational result and a
// load-enabled registered copy (plus the select that produced it).
module mux_2to1 #(
  parameter int unsigned           WIDTH       = 32,
  parameter logic [WIDTH-1:0]      RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] inputA,
  input  logic [WIDTH-1:0] inputB,
  input  logic             select,
  input  logic             load_en,
  output logic [WIDTH-1:0] outMux,
  output logic [WIDTH-1:0] outMux_q,
  output logic             sel_q
);

  // NOTE: the conditional operator (not if/case) is deliberate: with an unknown
  // select it merges both operands bitwise, so agreeing bits stay known and
  // neither input is silently preferred.
  assign outMux = select ? inputB : inputA;

  // NOTE: state is updated with non-blocking assignments so every register
  // samples pre-edge values; reset is synchronous and overrides load_en.
  always_ff @(posedge clk) begin
    if (rst) begin
      outMux_q <= RESET_VALUE;
      sel_q    <= 1'b0;
    end else if (load_en) begin
      outMux_q <= outMux;
      sel_q    <= select;
    end
  end

endmodule

// File: tb/tb_mux_2to1.sv
// Directed bench for mux_2to1: combinational result checked immediately,
// registered result checked one edge later from a scoreboard queue.
module tb_mux_2to1;

  localparam int W = 32;

  typedef struct {
    int         stepId;
    logic [W-1:0] q;
    logic         s;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] inputA;
  logic [W-1:0] inputB;
  logic         select;
  logic         load_en;
  logic [W-1:0] outMux;
  logic [W-1:0] outMux_q;
  logic         sel_q;

  exp_t         scoreboard[$];
  logic [W-1:0] modelQ;
  logic         modelS;
  int           stepCount = 0;
  int           checkCount = 0;
  int           passCount = 0;

  mux_2to1 #(.WIDTH(W), .RESET_VALUE('0)) dut (
    .clk      (clk),
    .rst      (rst),
    .inputA   (inputA),
    .inputB   (inputB),
    .select   (select),
    .load_en  (load_en),
    .outMux   (outMux),
    .outMux_q (outMux_q),
    .sel_q    (sel_q)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not reach its summary");
    $fatal(1, "timeout");
  end

  task automatic checkWord(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checkCount++;
    assert (obs === exp) passCount++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic checkBit(input string tag, input logic obs, input logic exp);
    checkCount++;
    assert (obs === exp) passCount++;
    else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
  endtask

  // One clocked step: drive at the falling edge, check outMux at once, queue
  // the registered expectation, then pop and compare just after the rising edge.
  task automatic step(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                      input logic r, input logic en, input logic [W-1:0] expMux);
    exp_t e;
    @(negedge clk);
    inputA = a; inputB = b; select = s; rst = r; load_en = en;
    #1;
    stepCount++;
    checkWord($sformatf("outMux step %0d", stepCount), outMux, expMux);
    if (r) begin
      modelQ = '0; modelS = 1'b0;
    end else if (en) begin
      modelQ = expMux; modelS = s;
    end
    e.stepId = stepCount; e.q = modelQ; e.s = modelS;
    scoreboard.push_back(e);
    @(posedge clk);
    #1;
    checkCount++;
    assert (scoreboard.size() > 0) passCount++;
    else $error("FAIL scoreboard empty at step %0d: observed 0 expected 1 entry", stepCount);
    if (scoreboard.size() > 0) begin
      e = scoreboard.pop_front();
      checkWord($sformatf("outMux_q step %0d", e.stepId), outMux_q, e.q);
      checkBit($sformatf("sel_q step %0d", e.stepId), sel_q, e.s);
    end
  endtask

  // Mid-cycle change: outMux follows at once, the registered path must not move.
  task automatic combOnly(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                          input logic [W-1:0] expMux);
    inputA = a; inputB = b; select = s;
    #1;
    checkWord("outMux mid-cycle", outMux, expMux);
    checkWord("outMux_q mid-cycle hold", outMux_q, modelQ);
  endtask

  initial begin
    rst = 1'b1; load_en = 1'b1; select = 1'b0; inputA = '0; inputB = '0;
    modelQ = '0; modelS = 1'b0;

    // Reset state, with outMux valid during reset.
    step(32'd14, 32'd31, 1'b0, 1'b1, 1'b1, 32'd14);

    // Basic select and toggling.
    step(32'd14, 32'd31, 1'b0, 1'b0, 1'b1, 32'd14);
    step(32'd14, 32'd31, 1'b1, 1'b0, 1'b1, 32'd31);
    combOnly(32'd14, 32'd31, 1'b0, 32'd14);
    combOnly(32'd23, 32'd31, 1'b0, 32'd23);
    combOnly(32'd23, 32'd31, 1'b1, 32'd31);
    step(32'd23, 32'd31, 1'b1, 1'b0, 1'b1, 32'd31);
    combOnly(32'd23, 32'd27, 1'b0, 32'd23);
    combOnly(32'd23, 32'd27, 1'b1, 32'd27);

    // Select toggling every cycle: outMux_q trails by one edge.
    step(32'd14, 32'd31, 1'b0, 1'b0, 1'b1, 32'd14);
    step(32'd14, 32'd31, 1'b1, 1'b0, 1'b1, 32'd31);
    step(32'd23, 32'd31, 1'b0, 1'b0, 1'b1, 32'd23);
    step(32'd23, 32'd31, 1'b1, 1'b0, 1'b1, 32'd31);
    step(32'd23, 32'd27, 1'b0, 1'b0, 1'b1, 32'd23);
    step(32'd23, 32'd27, 1'b1, 1'b0, 1'b1, 32'd27);

    // Mid-stream reset for two edges while inputs toggle, then release.
    step(32'h55, 32'hAA, 1'b0, 1'b1, 1'b1, 32'h55);
    step(32'h55, 32'hAA, 1'b1, 1'b1, 1'b1, 32'hAA);
    step(32'h55, 32'hAA, 1'b1, 1'b0, 1'b1, 32'hAA);

    // load_en low for three edges: registered path holds.
    step(32'hFFFF_FFFF, 32'h0, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFF);
    step(32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0);
    step(32'hFFFF_FFFF, 32'h0, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFF);

    // Reset wins over load_en low; then a normal load afterwards.
    step(32'hFFFF_FFFF, 32'h0, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFFF);
    step(32'hFFFF_FFFF, 32'h0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF);
    step(32'h1234_5678, 32'h8765_4321, 1'b1, 1'b0, 1'b1, 32'h8765_4321);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
